// File: rtl/ece429_operand_bypass_if.sv
// ece429_operand_bypass_if: decode, regfile and result buses around the operand bypass stage
interface ece429_operand_bypass_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
);
  logic              id_valid;
  logic [IDX_W-1:0]  id_rs;
  logic [IDX_W-1:0]  id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [IDX_W-1:0]  id_dest;
  logic              id_we;
  logic              id_load;
  logic [DATA_W-1:0] rf_rs_data;
  logic [DATA_W-1:0] rf_rt_data;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] mem_result;
  logic [DATA_W-1:0] wb_result;
  logic              flush;
  logic              id_stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs_val;
  logic [DATA_W-1:0] ex_rt_val;
  logic [IDX_W-1:0]  ex_dest;
  logic              ex_we;
  logic              ex_load;
  logic [IDX_W-1:0]  rf_wr_idx;
  logic              rf_wr_en;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_we, id_load,
    output rf_rs_data, rf_rt_data, ex_result, mem_result, wb_result, flush,
    input  id_stall, ex_valid, ex_rs_val, ex_rt_val, ex_dest, ex_we, ex_load,
    input  rf_wr_idx, rf_wr_en
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_we, id_load,
    input  rf_rs_data, rf_rt_data, ex_result, mem_result, wb_result, flush,
    output id_stall, ex_valid, ex_rs_val, ex_rt_val, ex_dest, ex_we, ex_load,
    output rf_wr_idx, rf_wr_en
  );
endinterface

// File: rtl/ece429_operand_bypass.sv
// ece429_operand_bypass: decode-to-execute operand stage with EX/MEM/WB forwarding and load-use stall
module ece429_operand_bypass #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input logic clock,
  input logic reset_n,
  ece429_operand_bypass_if.slave bus
);
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] dest;
    logic             we;
    logic             load;
  } slot_t;

  // Past EX only "does it write" and the destination matter, so MEM/WB keep a reduced tag.
  typedef struct packed {
    logic             wr;
    logic [IDX_W-1:0] dest;
  } tag_t;

  slot_t             exSlot, nextSlot;
  tag_t              memTag, wbTag;
  logic [DATA_W-1:0] rsVal, rtVal, rsFwd, rtFwd;
  logic              exWrites, rsEx, rsMem, rsWb, rtEx, rtMem, rtWb, stall, accept;

  function automatic logic hit(input logic wr, input logic [IDX_W-1:0] dest,
                               input logic en, input logic [IDX_W-1:0] idx);
    return en && wr && (dest == idx);
  endfunction

  always_comb begin
    exWrites = exSlot.valid && exSlot.we && (exSlot.dest != '0);
    rsEx     = hit(exWrites, exSlot.dest, bus.id_use_rs, bus.id_rs);
    rsMem    = hit(memTag.wr, memTag.dest, bus.id_use_rs, bus.id_rs);
    rsWb     = hit(wbTag.wr, wbTag.dest, bus.id_use_rs, bus.id_rs);
    rtEx     = hit(exWrites, exSlot.dest, bus.id_use_rt, bus.id_rt);
    rtMem    = hit(memTag.wr, memTag.dest, bus.id_use_rt, bus.id_rt);
    rtWb     = hit(wbTag.wr, wbTag.dest, bus.id_use_rt, bus.id_rt);
    rsFwd    = (bus.id_rs == '0) ? '0 : rsEx ? bus.ex_result : rsMem ? bus.mem_result :
               rsWb ? bus.wb_result : bus.rf_rs_data;
    rtFwd    = (bus.id_rt == '0) ? '0 : rtEx ? bus.ex_result : rtMem ? bus.mem_result :
               rtWb ? bus.wb_result : bus.rf_rt_data;
    // A load in EX has no data yet; one bubble moves it to MEM where it forwards normally.
    stall    = bus.id_valid && !bus.flush && exWrites && exSlot.load && (rsEx || rtEx);
    accept   = bus.id_valid && !stall && !bus.flush;
    nextSlot = accept ? {1'b1, bus.id_dest, bus.id_we, bus.id_load} : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exSlot <= '0;
      memTag <= '0;
      wbTag  <= '0;
      rsVal  <= '0;
      rtVal  <= '0;
    end else begin
      exSlot <= nextSlot;
      memTag <= {exWrites, exSlot.dest};
      wbTag  <= memTag;
      if (accept) begin
        rsVal <= rsFwd;
        rtVal <= rtFwd;
      end
    end
  end

  assign bus.id_stall  = stall;
  assign bus.ex_valid  = exSlot.valid;
  assign bus.ex_dest   = exSlot.dest;
  assign bus.ex_we     = exSlot.we;
  assign bus.ex_load   = exSlot.load;
  assign bus.ex_rs_val = rsVal;
  assign bus.ex_rt_val = rtVal;
  assign bus.rf_wr_idx = wbTag.dest;
  assign bus.rf_wr_en  = wbTag.wr;
endmodule
